// File: rtl/honzales_pkg.sv
// Shared constants, register map and helpers for the honzales counter slice.
package honzales_pkg;

    localparam int unsigned IO_PADS            = 38;
    localparam int unsigned DEFAULT_WIDTH      = 8;
    localparam int unsigned DEFAULT_PRESCALE_W = 16;
    localparam int unsigned DEFAULT_EN_PIN     = 32;
    localparam logic [31:0] DEFAULT_BASE_ADR   = 32'h3000_0000;

    localparam logic [3:0] CTRL_OFS     = 4'h0;
    localparam logic [3:0] COUNT_OFS    = 4'h4;
    localparam logic [3:0] PRESCALE_OFS = 4'h8;

    typedef enum logic [1:0] {
        RegCtrl,
        RegCount,
        RegPrescale,
        RegNone
    } reg_e;

    // Low address bits are ignored; registers are word-sized.
    function automatic reg_e decode_reg(input logic [3:0] ofs);
        reg_e r;
        unique case ({ofs[3:2], 2'b00})
            CTRL_OFS:     r = RegCtrl;
            COUNT_OFS:    r = RegCount;
            PRESCALE_OFS: r = RegPrescale;
            default:      r = RegNone;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/honzales_counter_if.sv
// Wishbone slave bundle between the management SoC and the user area.
interface honzales_counter_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i,
        output wbs_stb_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_adr_i,
        output wbs_dat_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i,
        input  wbs_stb_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_adr_i,
        input  wbs_dat_i,
        output wbs_ack_o,
        output wbs_dat_o
    );

endinterface

// File: rtl/honzales_count_core.sv
// Prescaled up-counter with clear > load > increment > prescale > hold priority.
module honzales_count_core
    import honzales_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ext_en_i,
    input  logic                  sw_en_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_val_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [WIDTH-1:0]      count_o
);

    logic [WIDTH-1:0]      count_d, count_q;
    logic [PRESCALE_W-1:0] pre_d, pre_q;

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        if (!ext_en_i) begin
            count_d = '0;
            pre_d   = '0;
        end else if (load_i) begin
            count_d = load_val_i;
            pre_d   = '0;
        end else if (sw_en_i) begin
            // A prescale value below pre_q waits for pre_q to wrap naturally.
            if (pre_q == prescale_i) begin
                count_d = count_q + WIDTH'(1);
                pre_d   = '0;
            end else begin
                pre_d = pre_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            pre_q   <= '0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/honzales_counter.sv
// Caravel user block: Wishbone register file plus a prescaled counter on the pads.
module honzales_counter
    import honzales_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W,
    parameter int unsigned EN_PIN     = DEFAULT_EN_PIN,
    parameter logic [31:0] BASE_ADR   = DEFAULT_BASE_ADR
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    honzales_counter_if.slave  wb,
    input  logic [IO_PADS-1:0] io_in,
    output logic [IO_PADS-1:0] io_out,
    output logic [IO_PADS-1:0] io_oeb
);

    localparam logic [IO_PADS-1:0] OEB_CONST = {{(IO_PADS - WIDTH){1'b1}}, {WIDTH{1'b0}}};

    logic                  ack_d, ack_q;
    logic [31:0]           dat_d, dat_q;
    logic                  sw_en_d, sw_en_q;
    logic [PRESCALE_W-1:0] prescale_d, prescale_q;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic [WIDTH-1:0]      count;
    logic                  hit, req;
    reg_e                  reg_sel;
    logic [31:0]           rdata, wdata;

    assign hit     = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    // Holding stb through the ack cycle must not start a second access.
    assign req     = hit & ~ack_q;
    assign reg_sel = decode_reg(wb.wbs_adr_i[3:0]);

    always_comb begin
        unique case (reg_sel)
            RegCtrl:     rdata = {31'b0, sw_en_q};
            RegCount:    rdata = 32'(count);
            RegPrescale: rdata = 32'(prescale_q);
            default:     rdata = '0;
        endcase
        wdata = be_merge(rdata, wb.wbs_dat_i, wb.wbs_sel_i);
    end

    always_comb begin
        ack_d      = req;
        dat_d      = '0;
        sw_en_d    = sw_en_q;
        prescale_d = prescale_q;
        load       = 1'b0;
        load_val   = count;
        if (req && wb.wbs_we_i) begin
            unique case (reg_sel)
                RegCtrl:     sw_en_d = wdata[0];
                RegCount: begin
                    load     = 1'b1;
                    load_val = wdata[WIDTH-1:0];
                end
                RegPrescale: prescale_d = wdata[PRESCALE_W-1:0];
                default: ;
            endcase
        end else if (req) begin
            dat_d = rdata;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            sw_en_q    <= 1'b1;
            prescale_q <= '0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            sw_en_q    <= sw_en_d;
            prescale_q <= prescale_d;
        end
    end

    honzales_count_core #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_core (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .ext_en_i   (io_in[EN_PIN]),
        .sw_en_i    (sw_en_q),
        .load_i     (load),
        .load_val_i (load_val),
        .prescale_i (prescale_q),
        .count_o    (count)
    );

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign io_out       = {{(IO_PADS - WIDTH){1'b0}}, count};
    assign io_oeb       = OEB_CONST;

    logic unused_sink;
    assign unused_sink = ^{io_in, wb.wbs_adr_i[1:0], wdata};

endmodule

// File: tb/tb_honzales_counter.sv
// Randomized scoreboard bench for honzales_counter against a cycle-level reference model.
module tb_honzales_counter;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    honzales_counter_if wb ();

    honzales_counter dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (wb),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc_n  = 0;
    bit   en_pin = 1'b1;

    // Reference state: plain integers, updated once per clock edge.
    int m_count = 0;
    int m_pre   = 0;
    int m_presc = 0;
    bit m_sw_en = 1'b1;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Drive one cycle of stimulus, predict its effect, and commit at the edge.
    task automatic step(input bit op, input bit we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat);
        bit   hit;
        int   ofs, rd, nc, np, npr;
        bit   nsw;
        exp_t e;
        wb.wbs_cyc_i = op;
        wb.wbs_stb_i = op;
        wb.wbs_we_i  = we;
        wb.wbs_sel_i = sel;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        io_in        = {$urandom, $urandom};
        io_in[32]    = en_pin;

        hit = op && (adr[31:4] == BASE[31:4]);
        ofs = int'(adr[3:0]);
        case (ofs)
            0:       rd = int'(m_sw_en);
            4:       rd = m_count;
            8:       rd = m_presc;
            default: rd = 0;
        endcase
        if (hit) begin
            e.cyc  = cyc_n + 1;
            e.rd   = !we;
            e.data = we ? 32'h0 : rd;
            sb.push_back(e);
        end

        nc = m_count; np = m_pre; npr = m_presc; nsw = m_sw_en;
        if (!en_pin) begin
            nc = 0; np = 0;
        end else if (hit && we && ofs == 4) begin
            if (sel[0]) nc = int'(dat[7:0]);
            np = 0;
        end else if (m_sw_en) begin
            if (m_pre == m_presc) begin
                nc = (m_count + 1) % 256; np = 0;
            end else begin
                np = (m_pre + 1) % 65536;
            end
        end
        if (hit && we && ofs == 0 && sel[0]) nsw = dat[0];
        if (hit && we && ofs == 8)
            npr = (sel[1] ? int'(dat[15:8]) : m_presc / 256) * 256
                + (sel[0] ? int'(dat[7:0]) : m_presc % 256);

        @(posedge clk);
        m_count = nc; m_pre = np; m_presc = npr; m_sw_en = nsw;
    endtask

    task automatic cycle(input bit op, input bit we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
        step(op, we, adr, sel, dat);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic wr(input logic [3:0] ofs, input logic [31:0] dat);
        cycle(1'b1, 1'b1, BASE | 32'(ofs), 4'hF, dat);
        idle(1);
    endtask

    task automatic rd(input logic [3:0] ofs);
        cycle(1'b1, 1'b0, BASE | 32'(ofs), 4'hF, 32'h0);
        idle(1);
    endtask

    // Monitor: per-cycle pad check plus scoreboard pop on every ack.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            chk("io_out", io_out, {30'b0, 8'(m_count)});
            if (wb.wbs_ack_o) begin
                if (sb.size() == 0) begin
                    chk("ack_spurious", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_cycle", cyc_n, e.cyc);
                    chk(e.rd ? "rd_data" : "wr_dat_o", wb.wbs_dat_o, e.data);
                end
            end else begin
                chk("dat_o_idle", wb.wbs_dat_o, 32'h0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = 32'h0; wb.wbs_dat_i = 32'h0;
        io_in        = 38'h0;
        io_in[32]    = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_io_out", io_out, 38'h0);
        chk("rst_ack", wb.wbs_ack_o, 1'b0);
        chk("rst_dat", wb.wbs_dat_o, 32'h0);
        chk("oeb", io_oeb, {30'h3FFF_FFFF, 8'h00});
        rst = 1'b0;

        // Free run through a wrap.
        idle(300);

        // Pull the external enable low once the count reaches 0x40.
        guard = 0;
        while (m_count != 'h40 && guard < 600) begin
            idle(1);
            guard++;
        end
        chk("reach_0x40", io_out[7:0], 8'h40);
        en_pin = 1'b0;
        idle(5);
        en_pin = 1'b1;
        idle(6);

        // Prescale by 4, then read it back.
        wr(4'h8, 32'h0000_0003);
        idle(20);
        rd(4'h8);
        idle(3);

        // Load near the top and watch the wrap.
        wr(4'h8, 32'h0);
        wr(4'h4, 32'h0000_00FE);
        idle(4);

        // Software disable holds the count.
        wr(4'h0, 32'h0);
        idle(5);
        rd(4'h4);
        wr(4'h0, 32'h1);
        idle(4);

        // Random traffic, including misses, partial selects and enable drops.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] adr, dat;
            logic [3:0]  ofs;
            ofs     = 4'($urandom_range(0, 3) * 4);
            adr     = ($urandom_range(0, 7) == 0) ? BASE + 32'h10 : BASE | 32'(ofs);
            dat     = $urandom;
            if (ofs == 4'h8) dat = dat & 32'h0000_0003;
            if (ofs == 4'h0 && $urandom_range(0, 3) != 0) dat[0] = 1'b1;
            en_pin  = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 2) == 0) begin
                cycle(1'b1, 1'($urandom), adr, 4'($urandom), dat);
                idle(1);
            end else begin
                idle(1);
            end
        end
        en_pin = 1'b1;

        // Async reset with count 0x80 and a read in flight.
        wr(4'h0, 32'h0);
        wr(4'h4, 32'h0000_0080);
        idle(1);
        chk("count_pre_rst", io_out[7:0], 8'h80);
        step(1'b1, 1'b0, BASE | 32'h4, 4'hF, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("async_io_out", io_out, 38'h0);
        chk("async_ack", wb.wbs_ack_o, 1'b0);
        sb.delete();
        m_count = 0; m_pre = 0; m_presc = 0; m_sw_en = 1'b1;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd(4'h0);
        rd(4'h8);
        idle(3);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
